// File: rtl/fft_peak_reader_if.sv
// Bus between the FFT peak reader and its surroundings.
// It carries the wrapper handshake, the result RAM port and the result handshake.
interface fft_peak_reader_if #(
  parameter int AW = 10
);
  logic          fft_ready;
  logic          fft_go;
  logic [AW-1:0] rd_addr_fft;
  logic [27:0]   ram_q;
  logic [AW-1:0] peak_bin;
  logic [27:0]   peak_mag;
  logic          result_valid;
  logic          result_ack;
  logic          overrun;
  logic          abort_err;

  modport master (
    input  fft_ready, ram_q, result_ack,
    output fft_go, rd_addr_fft, peak_bin, peak_mag, result_valid, overrun, abort_err
  );

  modport slave (
    output fft_ready, ram_q, result_ack,
    input  fft_go, rd_addr_fft, peak_bin, peak_mag, result_valid, overrun, abort_err
  );
endinterface

// File: rtl/fft_peak_reader.sv
// Scans the FFT result RAM, finds the peak-magnitude bin and hands it downstream.
// Define FFT_PEAK_MAG_L1_EN to use |re|+|im| instead of re^2+im^2 as the magnitude.
module fft_peak_reader #(
  parameter int FFT_PTS = 1024,
  parameter int BIN_LO  = 1,
  parameter int BIN_HI  = 511,
  parameter int RD_LAT  = 1
) (
  input  logic clk,
  input  logic rst_n,
  fft_peak_reader_if.master bus
);
  localparam int AW     = $clog2(FFT_PTS);
  localparam int STAGES = RD_LAT;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RELEASE} state_t;

  state_t                   state;
  logic [STAGES:0]          vld_pipe;
  logic [STAGES:0][AW-1:0]  bin_pipe;
  logic [27:0]              mag, mag_nx, best_mag;
  logic [AW-1:0]            best_bin;
  logic                     issue;
  logic signed [13:0]       re, im;

  assign re    = bus.ram_q[27:14];
  assign im    = bus.ram_q[13:0];
  assign issue = (state == SCAN) && bus.fft_ready;

`ifdef FFT_PEAK_MAG_L1_EN
  logic [14:0] re_abs, im_abs;

  // Negation via invert+1 in 15 bits so -8192 maps to +8192.
  assign re_abs = re[13] ? 15'(~re) + 15'd1 : 15'(re);
  assign im_abs = im[13] ? 15'(~im) + 15'd1 : 15'(im);
  assign mag_nx = 28'(re_abs) + 28'(im_abs);
`else
  logic signed [27:0] re_w, im_w;

  // The sum peaks at 2^27 (re=im=-8192); read as unsigned it still fits 28 bits.
  assign re_w   = 28'(re);
  assign im_w   = 28'(im);
  assign mag_nx = $unsigned(re_w * re_w) + $unsigned(im_w * im_w);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      vld_pipe         <= '0;
      bin_pipe         <= '0;
      mag              <= '0;
      best_mag         <= '0;
      best_bin         <= '0;
      bus.fft_go       <= 1'b0;
      bus.rd_addr_fft  <= '0;
      bus.peak_bin     <= '0;
      bus.peak_mag     <= '0;
      bus.result_valid <= 1'b0;
      bus.overrun      <= 1'b0;
      bus.abort_err    <= 1'b0;
    end else begin
      // Bit 0 is the address one cycle old; bit STAGES-1 lines up with ram_q.
      vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      bin_pipe <= {bin_pipe[STAGES-1:0], bus.rd_addr_fft};

      if (vld_pipe[STAGES-1])
        mag <= mag_nx;

      // Strictly greater: on a tie the earlier (lower) bin is kept.
      if (vld_pipe[STAGES] && (mag > best_mag)) begin
        best_mag <= mag;
        best_bin <= bin_pipe[STAGES];
      end

      if (bus.result_valid && bus.result_ack)
        bus.result_valid <= 1'b0;

      case (state)
        IDLE: begin
          bus.fft_go <= 1'b0;
          if (bus.fft_ready) begin
            bus.rd_addr_fft <= AW'(BIN_LO);
            best_mag        <= '0;
            best_bin        <= AW'(BIN_LO);
            state           <= SCAN;
          end
        end

        SCAN: begin
          if (!bus.fft_ready) begin
            bus.abort_err <= 1'b1;
            vld_pipe      <= '0;
            state         <= IDLE;
          end else begin
            bus.rd_addr_fft <= bus.rd_addr_fft + AW'(1);
            if (bus.rd_addr_fft == AW'(BIN_HI))
              state <= DRAIN;
          end
        end

        DRAIN: begin
          // A latch here overrides a same-cycle ack, which shows up as overrun.
          if (vld_pipe == '0) begin
            bus.peak_bin     <= best_bin;
            bus.peak_mag     <= best_mag;
            bus.result_valid <= 1'b1;
            if (bus.result_valid)
              bus.overrun <= 1'b1;
            bus.fft_go <= 1'b1;
            state      <= RELEASE;
          end
        end

        RELEASE: begin
          if (!bus.fft_ready) begin
            bus.fft_go <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_peak_reader.sv
// Scoreboard bench for fft_peak_reader: a RAM model feeds the DUT, and the expected peaks
// are queued at frame start and checked when fft_go rises.
module tb_fft_peak_reader;
  localparam int BIN_LO = 1;
  localparam int BIN_HI = 511;
  localparam int RD_LAT = 1;
  localparam int LAT    = BIN_HI - BIN_LO + 1 + RD_LAT + 3;

  typedef struct {
    logic [9:0]  bin;
    logic [27:0] mag;
    int          start;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rv_m = 1'b0;
  bit   ovr_m = 1'b0;
  exp_t sb[$];
  logic [27:0] mem [0:1023];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_peak_reader_if #(.AW(10)) bus ();

  fft_peak_reader #(
    .FFT_PTS(1024), .BIN_LO(BIN_LO), .BIN_HI(BIN_HI), .RD_LAT(RD_LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always @(posedge clk) bus.ram_q <= mem[bus.rd_addr_fft];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] mag_of(input logic [27:0] w);
    logic signed [13:0] r, i;
    longint re, im;
    r  = w[27:14];
    i  = w[13:0];
    re = r;
    im = i;
`ifdef FFT_PEAK_MAG_L1_EN
    return 28'((re < 0 ? -re : re) + (im < 0 ? -im : im));
`else
    return 28'(re * re + im * im);
`endif
  endfunction

  task automatic push_expected();
    exp_t e;
    e.bin = 10'(BIN_LO);
    e.mag = '0;
    for (int b = BIN_LO; b <= BIN_HI; b++)
      if (mag_of(mem[b]) > e.mag) begin
        e.mag = mag_of(mem[b]);
        e.bin = 10'(b);
      end
    e.start = cyc;
    sb.push_back(e);
  endtask

  task automatic fill(input logic [27:0] w);
    for (int b = 0; b < 1024; b++) mem[b] = w;
  endtask

  task automatic fill_rand();
    for (int b = 0; b < 1024; b++) mem[b] = 28'($urandom);
  endtask

  // One complete frame: raise fft_ready, wait for the release, then drop fft_ready.
  task automatic run_frame();
    bit seen;
    @(negedge clk);
    push_expected();
    bus.fft_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk);
      #1 seen = bus.fft_go;
    end
    chk("go_seen", seen, 1);
    repeat (4) @(posedge clk);
    #1 chk("go_held", bus.fft_go, 1);
    @(negedge clk) bus.fft_ready = 1'b0;
    @(posedge clk);
    #1 chk("go_release", bus.fft_go, 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic ack();
    @(negedge clk) bus.result_ack = 1'b1;
    @(posedge clk);
    #1 chk("ack_clears", bus.result_valid, 0);
    rv_m = 1'b0;
    @(negedge clk) bus.result_ack = 1'b0;
  endtask

  // Each rising edge of fft_go marks a latched result.
  initial begin
    exp_t e;
    bit   go_q, exp_ovr;
    go_q = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.fft_go && !go_q) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", bus.fft_go, 0);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc - e.start, LAT);
          chk("peak_bin", bus.peak_bin, e.bin);
          chk("peak_mag", bus.peak_mag, e.mag);
          chk("result_valid", bus.result_valid, 1);
          exp_ovr = ovr_m | rv_m;
          ovr_m   = exp_ovr;
          rv_m    = 1'b1;
          chk("overrun", bus.overrun, exp_ovr);
        end
      end
      go_q = bus.fft_go;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got %0d exp %0d", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    bus.fft_ready  = 1'b0;
    bus.result_ack = 1'b0;
    fill('0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_go", bus.fft_go, 0);
    chk("rst_addr", bus.rd_addr_fft, 0);
    chk("rst_bin", bus.peak_bin, 0);
    chk("rst_mag", bus.peak_mag, 0);
    chk("rst_valid", bus.result_valid, 0);
    chk("rst_ovr", bus.overrun, 0);
    chk("rst_abort", bus.abort_err, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single tone.
    fill({14'd10, 14'd10});
    mem[100] = {14'd1000, 14'd0};
    run_frame();
    ack();

    // Ties resolve to the lower bin; out-of-window bins are ignored.
    fill({14'd10, 14'd10});
    mem[0]   = {14'd8191, 14'd0};
    mem[600] = {14'd8191, 14'd0};
    mem[37]  = {14'h2000, 14'h2000};
    mem[200] = {14'h2000, 14'h2000};
    run_frame();
    ack();

    // All-zero frame.
    fill('0);
    run_frame();
    ack();

    // Two frames without an ack.
    fill_rand();
    run_frame();
    fill_rand();
    run_frame();
    chk("ovr_sticky", bus.overrun, 1);
    chk("ovr_valid_held", bus.result_valid, 1);
    ack();

    // Abort in SCAN cycle 50.
    chk("abort_before", bus.abort_err, 0);
    fill_rand();
    @(negedge clk) bus.fft_ready = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk) bus.fft_ready = 1'b0;
    @(posedge clk);
    #1 chk("abort_err", bus.abort_err, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_go", bus.fft_go, 0);
    chk("abort_no_valid", bus.result_valid, 0);
    run_frame();
    chk("abort_sticky", bus.abort_err, 1);
    ack();

    // Reset in DRAIN.
    fill_rand();
    @(negedge clk) bus.fft_ready = 1'b1;
    repeat (513) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus.fft_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_go", bus.fft_go, 0);
    chk("mid_rst_addr", bus.rd_addr_fft, 0);
    chk("mid_rst_bin", bus.peak_bin, 0);
    chk("mid_rst_mag", bus.peak_mag, 0);
    chk("mid_rst_valid", bus.result_valid, 0);
    chk("mid_rst_ovr", bus.overrun, 0);
    chk("mid_rst_abort", bus.abort_err, 0);
    rv_m  = 1'b0;
    ovr_m = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    chk("post_rst_go", bus.fft_go, 0);
    chk("post_rst_valid", bus.result_valid, 0);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_peak_reader.md
Name: fft_peak_reader

Overview:
- Consumer end of the per-channel FFT result RAM.
- Waits for the FFT wrapper's ready flag, then streams bin addresses into the result RAM and reads back {real, imag} words.
- Computes the magnitude of each bin in a search window and tracks the peak bin.
- Hands the peak to the localizer back-end, then releases the wrapper via its go input so the next frame can start.

Parameters:
- FFT_PTS, 1024: FFT length; address width is 10 bits.
- BIN_LO, 1: first bin searched (bin 0, DC, is skipped).
- BIN_HI, 511: last bin searched (Nyquist half of a real-input FFT).
- RD_LAT, 1: RAM read latency, in cycles from address to q.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- fft_ready  in  1  wrapper results complete (wrapper out_ready)
- fft_go  out  1  release request to wrapper go input
- rd_addr_fft  out  10  result RAM read address (registered)
- ram_q  in  28  RAM word: [27:14] real, [13:0] imag, both signed
- peak_bin  out  10  index of peak bin
- peak_mag  out  28  magnitude of peak bin, unsigned
- result_valid  out  1  peak_bin/peak_mag valid; held until ack
- result_ack  in  1  downstream consumed result
- overrun  out  1  sticky: new result latched while result_valid still high
- abort_err  out  1  sticky: fft_ready fell during SCAN

Behaviour:
- Reset values: fft_go=0, rd_addr_fft=0, peak_bin=0, peak_mag=0, result_valid=0, overrun=0, abort_err=0. FSM goes to IDLE.
- A reset asserted mid-frame aborts the frame immediately and discards pipeline contents.

FSM:
- IDLE
  - fft_go=0.
  - On fft_ready=1: rd_addr_fft<=BIN_LO, clear best_mag=0 and best_bin=BIN_LO, go to SCAN.
- SCAN
  - rd_addr_fft increments by 1 per cycle, with no stalls.
  - After issuing BIN_HI, go to DRAIN.
  - If fft_ready=0 in any SCAN cycle: set abort_err, flush the pipeline, go to IDLE. No result is produced.
- DRAIN
  - Wait until the in-flight pipeline is empty (RD_LAT+2 cycles after the last address).
  - Latch peak_bin=best_bin and peak_mag=best_mag. Set result_valid; if result_valid was already 1, set overrun.
  - Go to RELEASE.
- RELEASE
  - fft_go=1, held until fft_ready is sampled 0, then fft_go=0 and go to IDLE.
  - The wrapper double-syncs go, so the hold time is at least 4 cycles; there is no timeout.

Datapath:
- A valid bit delay line of RD_LAT stages tracks addresses in flight; each entry carries its bin index.
- Stage M (registered): mag = re*re + im*im.
  - Squares are 27-bit unsigned; the sum is 28-bit unsigned.
  - Maximum value 2^27, at re=im=-8192; no overflow.
- Stage C (registered): update best when mag > best_mag, strictly greater. On ties the lowest bin index wins.
- An all-zero frame yields peak_bin=BIN_LO, peak_mag=0.

Latency:
- Let cycle 0 be the IDLE cycle that samples fft_ready=1, and N = BIN_HI-BIN_LO+1.
- result_valid rises at cycle N+RD_LAT+3 (defaults: 515).
- fft_go rises in the same cycle.

Result handshake:
- result_valid falls in the cycle after result_ack=1 is sampled.
- If result_ack and a new latch occur in the same cycle, the latch wins: result_valid stays 1 and overrun is set.
- result_ack while result_valid=0 is ignored.
- overrun and abort_err clear only on reset.

Optional Feature:
- Macro: FFT_PEAK_MAG_L1_EN.
- Defined: magnitude = |re| + |im|.
  - The value is 15-bit unsigned (maximum 16384), zero-extended to 28 bits.
  - No multipliers are used; stage M latency is unchanged at 1 cycle.
- Undefined: squared magnitude as above.
- Comparison, tie rules and latency are identical in both builds.

Test Plan:
- Single tone: RAM bin 100 = (1000, 0), others (10, 10); pulse fft_ready -> result_valid at cycle 515 with peak_bin=100, peak_mag=1000000 (L1 build: 1000). fft_go stays high until fft_ready drops.
- Tie and skip: bins 0 and 600 = (8191, 0), bins 37 and 200 = (-8192, -8192) -> peak_bin=37, peak_mag=134217728. Bins 0 and 600 are ignored.
- Zero frame: all words 0 -> peak_bin=1, peak_mag=0.
- Overrun: never assert result_ack and run two frames -> second result visible, overrun=1 after the second latch, result_valid still 1. Then ack -> result_valid=0 next cycle.
- Abort: drop fft_ready at SCAN cycle 50 -> abort_err=1, no result_valid, FSM back to IDLE, and a subsequent frame completes normally.
- Reset mid-DRAIN: rst_n=0 for 1 cycle -> all outputs at reset values the next cycle, and no result is produced for that frame.
